soc_system_hps_pio_ext: RTL and testbench
=========================================

SOC_SYSTEM_HPS_PIO_EXT -- requirements
Module: soc_system_hps_pio_ext

Interface
REQ-001 Parameter DATA_WIDTH, default 8, port width in bits; SHALL accept 1..32.
REQ-002 Parameter RESET_VALUE, default 0, reset value of the output data register.
REQ-003 Parameter EDGE_TYPE, default 0, capture edge: 0 rising, 1 falling, 2 any.
REQ-004 Parameter SYNC_STAGES, default 2, input synchroniser depth; SHALL accept 2..4.
REQ-005 clk  input  1  clock; all state SHALL be rising-edge clocked.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 address  input  3  Avalon-MM word address.
REQ-008 chipselect  input  1  slave select.
REQ-009 write_n  input  1  active-low write strobe.
REQ-010 read_n  input  1  active-low read strobe.
REQ-011 writedata  input  32  write data; bits above DATA_WIDTH ignored.
REQ-012 readdata  output  32  registered read data; bits above DATA_WIDTH SHALL be 0.
REQ-013 in_port  input  DATA_WIDTH  asynchronous external inputs.
REQ-014 out_port  output  DATA_WIDTH  output data register.
REQ-015 oe  output  DATA_WIDTH  per-bit direction, 1 = output driven.
REQ-016 irq  output  1  registered level interrupt.

Function
REQ-017 Address map SHALL be: 0 data, 1 direction, 2 irqmask, 3 edgecapture, 4 outset, 5 outclear, 6 outtoggle, 7 reserved.
REQ-018 Write occurs when chipselect=1 and write_n=0; the addressed register SHALL update on that clock edge, visible on out_port/oe the following cycle.
REQ-019 Address 0 write SHALL load data_out; outset SHALL OR, outclear SHALL AND-NOT, outtoggle SHALL XOR writedata into data_out.
REQ-020 Address 1 write SHALL load direction; address 2 write SHALL load irqmask.
REQ-021 Address 3 write SHALL clear each edgecapture bit whose writedata bit is 1 (write-1-to-clear).
REQ-022 Writes to address 7 SHALL have no effect.
REQ-023 Read occurs when chipselect=1 and read_n=0; readdata SHALL present the value one clock later (1-cycle latency) and hold until the next read.
REQ-024 Data read per bit SHALL return data_out where direction=1, else synchronised in_port.
REQ-025 Addresses 1,2,3 SHALL read back their registers; addresses 4..7 SHALL read 0.
REQ-026 in_port SHALL pass through SYNC_STAGES flops, then a one-flop history register; edge detect compares last sync stage with history per EDGE_TYPE.
REQ-027 An input transition SHALL set its edgecapture bit on clock edge SYNC_STAGES+1 after first sampling, independent of direction.
REQ-028 Edgecapture bits SHALL remain set until cleared by software.
REQ-029 Same-cycle W1C clear and new edge on a bit: edge SHALL win; bit stays 1.
REQ-030 Simultaneous read and write to the same address: readdata SHALL return the pre-write value.
REQ-031 irq SHALL equal the registered OR of (edgecapture AND irqmask), one cycle after the contributing state.
REQ-032 chipselect=0 SHALL block all register side-effects; readdata unchanged.

Reset
REQ-033 While reset_n=0: data_out=RESET_VALUE, direction=0, irqmask=0, edgecapture=0, sync and history flops=0, readdata=0, irq=0.
REQ-034 Reset assertion mid-transaction SHALL abort it; no register update after reset release without a new strobe.
REQ-035 First cycle after release SHALL NOT register an edge from sync flops leaving reset (history reset matches sync reset).

Structure
REQ-036 Shared package soc_system_hps_pio_pkg SHALL hold address constants (ADDR_DATA..ADDR_TOGGLE) and EDGE_TYPE encodings.
REQ-037 One sub-module soc_system_hps_pio_sync SHALL implement the synchroniser chain, history flop and edge detect for DATA_WIDTH bits.
REQ-038 Top level SHALL hold the register file, read mux, write decode and irq register only.

Verification
REQ-039 Reset, DATA_WIDTH=8, RESET_VALUE=8'hA5: out_port=A5, oe=00, irq=0, read addr 1 -> 00 next cycle.
REQ-040 Write addr0=3C, addr4=01, addr5=0C, addr6=FF -> out_port 3C, 3D, 31, CE after each write.
REQ-041 direction=0F, data_out=AA, in_port=50 held 4 cycles, read addr0 -> readdata 0000005A.
REQ-042 EDGE_TYPE=0, irqmask=01, in_port bit0 0->1 -> edgecapture=01 at edge 3, irq=1 at edge 4; W1C 01 -> irq=0 two cycles later.
REQ-043 W1C of bit0 coinciding with new bit0 rising edge -> edgecapture bit0 remains 1, irq stays 1.
REQ-044 reset_n pulsed low with edgecapture=FF, irq=1 -> all zero asynchronously; no spurious capture after release with in_port static.

Source files
------------

// File: rtl/soc_system_hps_pio_pkg.sv
// Shared constants for the HPS PIO block: register map and edge encodings.
// Imported by the synchroniser and the register-file top level.
package soc_system_hps_pio_pkg;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_DIR    = 3'd1;
    localparam logic [2:0] ADDR_MASK   = 3'd2;
    localparam logic [2:0] ADDR_EDGE   = 3'd3;
    localparam logic [2:0] ADDR_SET    = 3'd4;
    localparam logic [2:0] ADDR_CLEAR  = 3'd5;
    localparam logic [2:0] ADDR_TOGGLE = 3'd6;
    localparam logic [2:0] ADDR_RSVD   = 3'd7;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/soc_system_hps_pio_sync.sv
// Input synchroniser chain, one-flop history and per-bit edge detect.
// History resets to the same value as the chain, so release is edge-free.
module soc_system_hps_pio_sync
    import soc_system_hps_pio_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int EDGE_TYPE   = EDGE_RISING,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] sync_in,
    output logic [DATA_WIDTH-1:0] edge_hit
);

    logic [DATA_WIDTH-1:0] stage [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] hist;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage[i] <= '0;
            end
            hist <= '0;
        end else begin
            stage[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
            hist <= stage[SYNC_STAGES-1];
        end
    end

    assign sync_in = stage[SYNC_STAGES-1];

    always_comb begin
        edge_hit = sync_in & ~hist;
        if (EDGE_TYPE == EDGE_FALLING) begin
            edge_hit = ~sync_in & hist;
        end else if (EDGE_TYPE == EDGE_ANY) begin
            edge_hit = sync_in ^ hist;
        end
    end

endmodule

// File: rtl/soc_system_hps_pio_ext.sv
// Avalon-MM PIO with direction control, set/clear/toggle aliases,
// sticky edge capture and a masked level interrupt.
module soc_system_hps_pio_ext
    import soc_system_hps_pio_pkg::*;
#(
    parameter int          DATA_WIDTH  = 8,
    parameter logic [31:0] RESET_VALUE = '0,
    parameter int          EDGE_TYPE   = EDGE_RISING,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic                  read_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic [DATA_WIDTH-1:0] oe,
    output logic                  irq
);

    logic [DATA_WIDTH-1:0] data_out;
    logic [DATA_WIDTH-1:0] direction;
    logic [DATA_WIDTH-1:0] irqmask;
    logic [DATA_WIDTH-1:0] edgecapture;
    logic [DATA_WIDTH-1:0] sync_in;
    logic [DATA_WIDTH-1:0] edge_hit;
    logic [DATA_WIDTH-1:0] wd;
    logic [DATA_WIDTH-1:0] ec_clr;
    logic [DATA_WIDTH-1:0] rd_mux;
    logic                  wr;
    logic                  rd;
    logic                  unused_wd;

    soc_system_hps_pio_sync #(
        .DATA_WIDTH  (DATA_WIDTH),
        .EDGE_TYPE   (EDGE_TYPE),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_port  (in_port),
        .sync_in  (sync_in),
        .edge_hit (edge_hit)
    );

    assign wr        = chipselect && !write_n;
    assign rd        = chipselect && !read_n;
    assign wd        = writedata[DATA_WIDTH-1:0];
    assign unused_wd = ^(writedata >> DATA_WIDTH);
    assign out_port  = data_out;
    assign oe        = direction;

    // A fresh edge is OR'd in after the clear so it wins a collision.
    assign ec_clr = (wr && address == ADDR_EDGE) ? wd : '0;

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA: rd_mux = (data_out & direction)
                              | (sync_in & ~direction);
            ADDR_DIR:  rd_mux = direction;
            ADDR_MASK: rd_mux = irqmask;
            ADDR_EDGE: rd_mux = edgecapture;
            default:   rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out    <= RESET_VALUE[DATA_WIDTH-1:0];
            direction   <= '0;
            irqmask     <= '0;
            edgecapture <= '0;
            readdata    <= '0;
            irq         <= 1'b0;
        end else begin
            if (wr) begin
                case (address)
                    ADDR_DATA:   data_out  <= wd;
                    ADDR_DIR:    direction <= wd;
                    ADDR_MASK:   irqmask   <= wd;
                    ADDR_SET:    data_out  <= data_out | wd;
                    ADDR_CLEAR:  data_out  <= data_out & ~wd;
                    ADDR_TOGGLE: data_out  <= data_out ^ wd;
                    default:     ;
                endcase
            end
            edgecapture <= (edgecapture & ~ec_clr) | edge_hit;
            if (rd) begin
                readdata <= 32'(rd_mux);
            end
            irq <= |(edgecapture & irqmask);
        end
    end

endmodule

// File: tb/tb_soc_system_hps_pio_ext.sv
// Randomised and directed bench for the HPS PIO against a cycle model
// built from input sample history and register semantics.
module tb_soc_system_hps_pio_ext;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic        read_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [7:0]  in_port = '0;
    logic [7:0]  out_port;
    logic [7:0]  oe;
    logic        irq;

    int total = 0;
    int bad = 0;

    logic [7:0]  m_do, m_dir, m_mask, m_ec;
    logic [31:0] m_rd;
    logic        m_irq;
    logic [7:0]  smp [0:S];

    soc_system_hps_pio_ext #(
        .DATA_WIDTH  (8),
        .RESET_VALUE (32'hA5),
        .EDGE_TYPE   (0),
        .SYNC_STAGES (S)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .read_n     (read_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .out_port   (out_port),
        .oe         (oe),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_do = 8'hA5;
        m_dir = '0;
        m_mask = '0;
        m_ec = '0;
        m_rd = '0;
        m_irq = 1'b0;
        for (int i = 0; i <= S; i++) smp[i] = '0;
    endtask

    // smp[k] is the in_port value sampled k+1 edges ago
    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0: return {24'h0, (m_do & m_dir) | (smp[S-1] & ~m_dir)};
            3'd1: return {24'h0, m_dir};
            3'd2: return {24'h0, m_mask};
            3'd3: return {24'h0, m_ec};
            default: return 32'h0;
        endcase
    endfunction

    task automatic tick();
        logic wr, rd;
        logic [7:0] e, wd, n_do, n_dir, n_mask, n_ec, in_pre;
        logic [31:0] n_rd;
        logic n_irq;
        wr = chipselect && !write_n;
        rd = chipselect && !read_n;
        wd = writedata[7:0];
        e = smp[S-1] & ~smp[S];
        n_do = m_do;
        n_dir = m_dir;
        n_mask = m_mask;
        n_ec = m_ec | e;
        if (wr && address == 3'd3) n_ec = (m_ec & ~wd) | e;
        if (wr) begin
            case (address)
                3'd0: n_do = wd;
                3'd1: n_dir = wd;
                3'd2: n_mask = wd;
                3'd4: n_do = m_do | wd;
                3'd5: n_do = m_do & ~wd;
                3'd6: n_do = m_do ^ wd;
                default: ;
            endcase
        end
        n_rd = rd ? m_read(address) : m_rd;
        n_irq = |(m_ec & m_mask);
        in_pre = in_port;
        @(posedge clk);
        #1;
        if (!reset_n) begin
            model_reset();
        end else begin
            m_do = n_do;
            m_dir = n_dir;
            m_mask = n_mask;
            m_ec = n_ec;
            m_rd = n_rd;
            m_irq = n_irq;
            for (int i = S; i > 0; i--) smp[i] = smp[i-1];
            smp[0] = in_pre;
        end
    endtask

    task automatic idle();
        chipselect = 1'b0;
        write_n = 1'b1;
        read_n = 1'b1;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n = 1'b0;
        read_n = 1'b1;
        address = a;
        writedata = d;
        tick();
        idle();
    endtask

    task automatic do_read(input logic [2:0] a);
        chipselect = 1'b1;
        write_n = 1'b1;
        read_n = 1'b0;
        address = a;
        tick();
        idle();
    endtask

    task automatic test_reset();
        model_reset();
        reset_n = 1'b0;
        tick();
        tick();
        total++;
        if (out_port !== 8'hA5) begin
            bad++;
            $display("FAIL rst_out got=%h exp=a5", out_port);
        end
        total++;
        if (oe !== 8'h00 || irq !== 1'b0) begin
            bad++;
            $display("FAIL rst_oe_irq got=%h/%b exp=00/0", oe, irq);
        end
        total++;
        if (readdata !== 32'h0) begin
            bad++;
            $display("FAIL rst_rd got=%h exp=0", readdata);
        end
        reset_n = 1'b1;
        tick();
        do_read(3'd1);
        total++;
        if (readdata !== 32'h0 || readdata !== m_rd) begin
            bad++;
            $display("FAIL rst_dir_read got=%h exp=0", readdata);
        end
    endtask

    task automatic test_out_ops();
        logic [2:0] a [4];
        logic [7:0] d [4];
        logic [7:0] x [4];
        a = '{3'd0, 3'd4, 3'd5, 3'd6};
        d = '{8'h3C, 8'h01, 8'h0C, 8'hFF};
        x = '{8'h3C, 8'h3D, 8'h31, 8'hCE};
        for (int i = 0; i < 4; i++) begin
            do_write(a[i], {24'hFFFFFF, d[i]});
            total++;
            if (out_port !== x[i] || out_port !== m_do) begin
                bad++;
                $display("FAIL out_op%0d got=%h exp=%h",
                         i, out_port, x[i]);
            end
        end
    endtask

    task automatic test_read_mix();
        do_write(3'd1, 32'h0F);
        do_write(3'd0, 32'hAA);
        in_port = 8'h50;
        repeat (4) tick();
        do_read(3'd0);
        total++;
        if (readdata !== 32'h5A || readdata !== m_rd) begin
            bad++;
            $display("FAIL read_mix got=%h exp=0000005a", readdata);
        end
        total++;
        if (oe !== 8'h0F) begin
            bad++;
            $display("FAIL oe got=%h exp=0f", oe);
        end
    endtask

    task automatic test_edge_irq();
        logic [2:0] exp_irq [3];
        exp_irq = '{1'b0, 1'b0, 1'b0};
        do_write(3'd3, 32'hFF);
        do_write(3'd2, 32'h01);
        in_port = 8'h00;
        repeat (4) tick();
        do_write(3'd3, 32'hFF);
        tick();
        tick();
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL edge_pre irq=%b exp=0", irq);
        end
        in_port = 8'h01;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (irq !== exp_irq[i][0]) begin
                bad++;
                $display("FAIL edge_e%0d irq=%b exp=0", i + 1, irq);
            end
        end
        do_read(3'd3);
        total++;
        if (readdata !== 32'h1 || irq !== 1'b1) begin
            bad++;
            $display("FAIL edge_e4 got=%h/%b exp=1/1", readdata, irq);
        end
        do_write(3'd3, 32'h01);
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL w1c_k irq=%b exp=1", irq);
        end
        tick();
        total++;
        if (irq !== 1'b0 || irq !== m_irq) begin
            bad++;
            $display("FAIL w1c_k1 irq=%b exp=0", irq);
        end
    endtask

    task automatic test_w1c_collision();
        in_port = 8'h00;
        repeat (4) tick();
        in_port = 8'h01;
        repeat (4) tick();
        in_port = 8'h00;
        repeat (4) tick();
        in_port = 8'h01;
        tick();
        tick();
        do_write(3'd3, 32'h01);
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL coll_irq0 irq=%b exp=1", irq);
        end
        tick();
        total++;
        if (irq !== 1'b1 || irq !== m_irq) begin
            bad++;
            $display("FAIL coll_irq1 irq=%b exp=1", irq);
        end
        do_read(3'd3);
        total++;
        if (readdata !== 32'h1 || readdata !== m_rd) begin
            bad++;
            $display("FAIL coll_ec got=%h exp=1", readdata);
        end
    endtask

    task automatic test_same_addr();
        chipselect = 1'b1;
        write_n = 1'b0;
        read_n = 1'b0;
        address = 3'd1;
        writedata = 32'h33;
        tick();
        idle();
        total++;
        if (readdata !== 32'h0F || readdata !== m_rd) begin
            bad++;
            $display("FAIL rw_same got=%h exp=0f", readdata);
        end
        do_read(3'd1);
        total++;
        if (readdata !== 32'h33 || oe !== 8'h33) begin
            bad++;
            $display("FAIL rw_after got=%h/%h exp=33", readdata, oe);
        end
    endtask

    task automatic test_reset_mid();
        do_write(3'd2, 32'hFF);
        in_port = 8'h00;
        repeat (4) tick();
        in_port = 8'hFF;
        repeat (5) tick();
        in_port = 8'h00;
        repeat (4) tick();
        do_read(3'd3);
        total++;
        if (readdata !== 32'hFF || irq !== 1'b1) begin
            bad++;
            $display("FAIL pre_rst got=%h/%b exp=ff/1", readdata, irq);
        end
        #1;
        chipselect = 1'b1;
        write_n = 1'b0;
        address = 3'd0;
        writedata = 32'h11;
        reset_n = 1'b0;
        #1;
        total++;
        if (irq !== 1'b0 || readdata !== 32'h0 || oe !== 8'h0
            || out_port !== 8'hA5) begin
            bad++;
            $display("FAIL async_rst got=%b/%h/%h/%h exp=0/0/0/a5",
                     irq, readdata, oe, out_port);
        end
        model_reset();
        tick();
        tick();
        idle();
        reset_n = 1'b1;
        repeat (6) tick();
        total++;
        if (out_port !== 8'hA5 || irq !== 1'b0) begin
            bad++;
            $display("FAIL post_rst got=%h/%b exp=a5/0", out_port, irq);
        end
        do_read(3'd3);
        total++;
        if (readdata !== 32'h0 || readdata !== m_rd) begin
            bad++;
            $display("FAIL post_rst_ec got=%h exp=0", readdata);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            address = 3'($urandom_range(0, 7));
            chipselect = ($urandom_range(0, 3) != 0);
            write_n = 1'($urandom % 2);
            read_n = 1'($urandom % 2);
            writedata = $urandom;
            if ($urandom_range(0, 3) == 0) in_port = 8'($urandom);
            tick();
            total++;
            if (out_port !== m_do || oe !== m_dir || irq !== m_irq
                || readdata !== m_rd) begin
                bad++;
                $display("FAIL rand%0d got=%h/%h/%b/%h exp=%h/%h/%b/%h",
                         n, out_port, oe, irq, readdata,
                         m_do, m_dir, m_irq, m_rd);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_out_ops();
        test_read_mix();
        test_edge_irq();
        test_w1c_collision();
        test_same_addr();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
